// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - multicycle MIPS main controller FSM; define MC_MAIN_FSM_JUMP_EN to decode j
module mc_main_fsm #(
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             lord,
  output logic             ALUSrcA,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             RegWrite,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int SW = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_MAIN_FSM_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] stall_cnt;
  logic          wait_state;
  logic          retire;

  assign state = state_q;

  // State register, retirement counter and sticky memory-stall watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_cnt   <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_cnt <= instr_cnt + 1'b1;
      end
      if (wait_state && !mem_ready) begin
        // saturate so a very long stall cannot wrap back below the threshold
        if (stall_cnt != SW'(WAIT_TIMEOUT)) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        if (stall_cnt >= SW'(WAIT_TIMEOUT - 1)) begin
          mem_timeout <= 1'b1;
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  // Next-state decode and Moore datapath controls (FETCH strobes follow mem_ready)
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    wait_state = 1'b0;
    illegal_op = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    lord       = 1'b0;
    ALUSrcA    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        wait_state = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
`ifdef MC_MAIN_FSM_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        lord       = 1'b1;
        wait_state = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEMWRITE: begin
        lord       = 1'b1;
        MemWrite   = 1'b1;
        wait_state = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`ifdef MC_MAIN_FSM_JUMP_EN
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb/tb_mc_main_fsm.sv - self-checking bench for mc_main_fsm against an instruction-route model
module tb_mc_main_fsm;

  localparam int CNT_W = 2;
  localparam int WT    = 4;
`ifdef MC_MAIN_FSM_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       Opcode = 6'd0;
  logic             mem_ready = 1'b1;
  logic             MemtoReg, RegDst, lord, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite;
  logic [1:0]       PCSrc, ALUSrcB, ALUOp;
  logic [3:0]       state;
  logic             illegal_op, mem_timeout;
  logic [CNT_W-1:0] instr_cnt;

  always #5 clk = ~clk;

  mc_main_fsm #(.CNT_W(CNT_W), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .lord(lord), .ALUSrcA(ALUSrcA),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic mtr, rdst, lord, asa, irw, mw, pcw, br, rw;
    logic [1:0] pcs, asb, aop;
  } ctrl_t;
  typedef int iq_t[$];

  ctrl_t dut_ctrl;
  assign dut_ctrl = {MemtoReg, RegDst, lord, ALUSrcA, IRWrite, MemWrite, PCWrite,
                     Branch, RegWrite, PCSrc, ALUSrcB, ALUOp};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // the states an opcode walks through after DECODE; empty means illegal
  function automatic iq_t route(input logic [5:0] op);
    iq_t q;
    q = {};
    case (op)
      6'd0:  q = {6, 7};
      6'd35: q = {2, 3, 4};
      6'd43: q = {2, 5};
      6'd4:  q = {8};
      6'd8:  q = {9, 10};
      6'd2:  if (JUMP_EN) q = {11};
      default: ;
    endcase
    return q;
  endfunction

  function automatic ctrl_t exp_ctrl(input int s, input logic mr);
    ctrl_t c;
    c = '0;
    case (s)
      0:    begin c.asb = 2'd1; c.irw = mr; c.pcw = mr; end
      1:    c.asb = 2'd3;
      2, 9: begin c.asa = 1'b1; c.asb = 2'd2; end
      3:    c.lord = 1'b1;
      4:    begin c.mtr = 1'b1; c.rw = 1'b1; end
      5:    begin c.lord = 1'b1; c.mw = 1'b1; end
      6:    begin c.asa = 1'b1; c.aop = 2'd2; end
      7:    begin c.rdst = 1'b1; c.rw = 1'b1; end
      8:    begin c.asa = 1'b1; c.aop = 2'd1; c.pcs = 2'd1; c.br = 1'b1; end
      10:   c.rw = 1'b1;
      11:   begin c.pcs = 2'd2; c.pcw = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  bit  model_valid = 1'b0;
  int  m_state = 0;
  int  m_cnt = 0;
  int  m_stall = 0;
  bit  m_to = 1'b0;
  iq_t plan;

  // Reference model: walk the opcode's route, wait states hold while memory is not ready
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_cnt = 0; m_stall = 0; m_to = 1'b0; plan = {};
      model_valid = 1'b1;
    end else if (model_valid) begin
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
        m_stall++;
        if (m_stall >= WT) m_to = 1'b1;
      end else begin
        m_stall = 0;
        if (m_state == 0) m_state = 1;
        else if (m_state == 1) begin
          plan = route(Opcode);
          if (plan.size() == 0) m_state = 0;
          else m_state = plan.pop_front();
        end else if (plan.size() != 0) m_state = plan.pop_front();
        else begin
          m_state = 0;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (model_valid) begin
      iq_t r;
      r = route(Opcode);
      chk("state", 32'(state), m_state);
      chk("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(m_state, mem_ready)));
      chk("illegal_op", 32'(illegal_op), (m_state == 1 && r.size() == 0) ? 1 : 0);
      chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
      chk("instr_cnt", 32'(instr_cnt), m_cnt);
    end
  end

  task automatic drive(input logic r, input logic m, input logic [5:0] op);
    @(posedge clk);
    #1;
    rst = r; mem_ready = m; Opcode = op;
    @(negedge clk);
  endtask

  task automatic sc(input logic m, input logic [5:0] op, input int exp_state, input string nm);
    drive(1'b0, m, op);
    chk(nm, 32'(state), exp_state);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'd0;
      1: return 6'd35;
      2: return 6'd43;
      3: return 6'd4;
      4: return 6'd8;
      5: return 6'd2;
      6: return 6'd63;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  // Directed scenarios with hand-computed expectations, then randomized traffic
  initial begin
    int burst;
    logic [5:0] op;
    burst = 0;

    drive(1, 1, 0); drive(1, 1, 0);
    chk("reset_state", 32'(state), 0);
    chk("reset_cnt", 32'(instr_cnt), 0);
    chk("reset_timeout", 32'(mem_timeout), 0);
    chk("reset_irwrite", 32'(IRWrite), 1);

    sc(1, 0, 0, "rt_s0"); sc(1, 0, 1, "rt_s1"); sc(1, 0, 6, "rt_s6"); sc(1, 0, 7, "rt_s7");
    chk("rt_regdst", 32'(RegDst), 1);
    chk("rt_regwrite", 32'(RegWrite), 1);
    chk("rt_cnt_before", 32'(instr_cnt), 0);
    sc(1, 0, 0, "rt_back");
    chk("rt_cnt_after", 32'(instr_cnt), 1);

    drive(1, 1, 35);
    sc(1, 35, 0, "lw_s0"); sc(1, 35, 1, "lw_s1"); sc(1, 35, 2, "lw_s2");
    for (int i = 0; i < 4; i++) begin
      sc((i == 3), 35, 3, "lw_wait");
      chk("lw_lord", 32'(lord), 1);
    end
    sc(1, 35, 4, "lw_s4");
    chk("lw_memtoreg", 32'(MemtoReg), 1);
    chk("lw_regwrite", 32'(RegWrite), 1);
    sc(1, 35, 0, "lw_back");
    chk("lw_cnt", 32'(instr_cnt), 1);

    drive(1, 1, 43);
    sc(1, 43, 0, "sw_s0"); sc(1, 43, 1, "sw_s1"); sc(1, 43, 2, "sw_s2"); sc(0, 43, 5, "sw_s5");
    chk("sw_memwrite", 32'(MemWrite), 1);
    drive(1, 0, 43);
    chk("sw_rst_cycle", 32'(state), 5);
    drive(0, 0, 43);
    chk("sw_rst_state", 32'(state), 0);
    chk("sw_rst_memwrite", 32'(MemWrite), 0);
    chk("sw_rst_cnt", 32'(instr_cnt), 0);

    drive(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      sc(0, 0, 0, "to_fetch");
      chk("to_not_yet", 32'(mem_timeout), 0);
    end
    sc(1, 0, 0, "to_fetch_ready");
    chk("to_set", 32'(mem_timeout), 1);
    chk("to_irwrite", 32'(IRWrite), 1);
    sc(1, 0, 1, "to_decode");
    chk("to_sticky", 32'(mem_timeout), 1);

    drive(1, 1, 2);
    sc(1, 2, 0, "j_s0"); sc(1, 2, 1, "j_s1");
    chk("j_illegal", 32'(illegal_op), JUMP_EN ? 0 : 1);
`ifdef MC_MAIN_FSM_JUMP_EN
    sc(1, 2, 11, "j_s11");
    chk("j_pcsrc", 32'(PCSrc), 2);
    chk("j_pcwrite", 32'(PCWrite), 1);
    sc(1, 2, 0, "j_back");
    chk("j_cnt", 32'(instr_cnt), 1);
`else
    sc(1, 2, 0, "j_back");
    chk("j_cnt", 32'(instr_cnt), 0);
`endif

    drive(1, 1, 63);
    sc(1, 63, 0, "ill_s0"); sc(1, 63, 1, "ill_s1");
    chk("ill_flag", 32'(illegal_op), 1);
    sc(1, 63, 0, "ill_back");
    chk("ill_cnt", 32'(instr_cnt), 0);
    chk("ill_clear", 32'(illegal_op), 0);

    drive(1, 1, 4);
    for (int k = 0; k < 5; k++) begin
      sc(1, 4, 0, "beq_s0");
      chk("wrap_cnt", 32'(instr_cnt), k % 4);
      sc(1, 4, 1, "beq_s1");
      sc(1, 4, 8, "beq_s8");
      chk("beq_branch", 32'(Branch), 1);
      chk("beq_pcsrc", 32'(PCSrc), 1);
      chk("beq_aluop", 32'(ALUOp), 1);
    end
    sc(1, 4, 0, "beq_back");
    chk("wrap_cnt_last", 32'(instr_cnt), 1);

    drive(1, 1, 0);
    repeat (3000) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      if (burst > 0) begin
        mem_ready = 1'b0;
        burst--;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) burst = $urandom_range(3, 7);
      end
      op = (m_state == 0) ? pick_op() : Opcode;
      Opcode = op;
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
# mc_main_fsm

Multicycle MIPS main controller with memory wait handshake and instruction retirement accounting; the parametrised successor of `main_decoder`. Sits between the instruction register opcode field and the datapath muxes/enables of the multicycle core. Supports R-type, lw, sw, beq, addi and (optionally) j, and stalls on a `mem_ready` handshake. Counts retired instructions and flags memory timeouts and illegal opcodes.

## Interface
- `CNT_W`, 16: width of retired-instruction counter.
- `WAIT_TIMEOUT`, 15: stall cycles (≥1) after which `mem_timeout` sets.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `Opcode`  in  6  instr[31:26]; stable from DECODE until the return to FETCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `MemtoReg`, `RegDst`, `lord`, `ALUSrcA`, `IRWrite`, `MemWrite`, `PCWrite`, `Branch`, `RegWrite`  out  1 each  datapath controls.
- `PCSrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `ALUSrcB`, `ALUOp`  out  2 each.
- `state`  out  4  current state code.
- `illegal_op`  out  1  unsupported opcode seen in DECODE.
- `mem_timeout`  out  1  sticky; stall exceeded WAIT_TIMEOUT.
- `instr_cnt`  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11; codes 12–15 go to FETCH.
- Outputs (unlisted = 0):
  - FETCH: ALUSrcB=01, `IRWrite`=`PCWrite`=`mem_ready`.
  - DECODE: ALUSrcB=11.
  - MEMADR, ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMREAD: lord=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWRITE: lord=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH→DECODE on `mem_ready`, else hold.
  - DECODE by opcode: 000000→EXECUTE; 100011/101011→MEMADR; 000100→BRANCH; 001000→ADDIEXEC; 000010→JUMP; otherwise →FETCH with `illegal_op`=1 that cycle.
  - MEMADR→MEMREAD (lw) / MEMWRITE (sw).
  - MEMREAD→MEMWB on `mem_ready`, else hold.
  - MEMWRITE→FETCH on `mem_ready`, else hold; MemWrite stays high throughout.
  - EXECUTE→ALUWB; ADDIEXEC→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- `instr_cnt` increments by 1 when leaving MEMWB, ALUWB, ADDIWB, BRANCH or JUMP, and when leaving MEMWRITE. Illegal opcodes do not count.
- Stall counter:
  - Counts consecutive cycles in FETCH/MEMREAD/MEMWRITE with `mem_ready`=0; clears on `mem_ready`=1 or state change.
  - When it reaches WAIT_TIMEOUT, `mem_timeout` sets and holds until `rst`.
  - The FSM keeps waiting; it never aborts.

## Timing
- Moore outputs from the state register; only FETCH's IRWrite/PCWrite and `illegal_op` are combinational on inputs.
- Reset: state=FETCH, instr_cnt=0, stall count=0, mem_timeout=0. Outputs follow FETCH (IRWrite=PCWrite=`mem_ready`).
- `rst` overrides everything, including mid-instruction (e.g. during MEMWRITE: next cycle FETCH, MemWrite=0, no count).
- Latency with `mem_ready` held 1:
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j: 3 cycles.
- Each low cycle of `mem_ready` in a wait state adds one cycle.

## Configuration
- `MC_MAIN_FSM_JUMP_EN` defined: j (000010) decodes to JUMP as above.
- Not defined: JUMP state and PCSrc=10 are never produced, and 000010 is treated as illegal (`illegal_op`=1, return to FETCH).

## Test plan
- **R-type**, mem_ready=1, from reset: states 0,1,6,7,0; ALUWB shows RegDst=1, RegWrite=1; instr_cnt 0→1.
- **lw, slow memory**: mem_ready=0 for 3 cycles in MEMREAD: lord=1 for 4 cycles, then MEMWB (MemtoReg=1, RegWrite=1); 8 cycles total; instr_cnt+1.
- **sw, reset mid-access**: assert rst during MEMWRITE with mem_ready=0: next cycle state=0, MemWrite=0, instr_cnt unchanged (0).
- **Timeout**: WAIT_TIMEOUT=4, mem_ready=0 in FETCH: mem_timeout=1 after 4th stall cycle, stays 1 after mem_ready rises; FSM proceeds to DECODE.
- **Jump/illegal**: Opcode=000010 with macro → states 0,1,11,0, PCSrc=10, PCWrite=1. Without macro → illegal_op=1 in DECODE, then state 0, no count. Opcode=111111 → illegal in both builds.
- **Counter wrap**: CNT_W=2, five beq instructions: instr_cnt 1,2,3,0,1. Branch=1, PCSrc=01, ALUOp=01 in each BRANCH.
